frost32_mem_bridge: RTL and testbench

- Sits directly downstream of the Frost32 CPU core's memory-access port.
- Consumes the CPU's request: data, address, access type (read/write) and access size (32/16/8/bad).
- Drives a single-port synchronous word-wide RAM with byte enables.
- Returns read data and the wait_for_mem stall signal to the CPU.
- Performs byte-lane steering, alignment checking and read-latency sequencing.

---
 rtl/frost32_mem_bridge_if.sv | 35 +++
 rtl/frost32_mem_bridge.sv | 195 +++++++++++++++++++
 tb/tb_frost32_mem_bridge.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/frost32_mem_bridge_if.sv
// Bus bundle between the Frost32 memory-access port, the bridge and the word-wide RAM.
// The slave modport is the bridge's view; master is the CPU-plus-RAM side.
`timescale 1ns/1ps
interface frost32_mem_bridge_if #(
  parameter int MEM_ADDR_WIDTH = 14
);
  logic [31:0]               cpu_data_out;
  logic [31:0]               cpu_addr;
  logic                      cpu_access_type;
  logic [1:0]                cpu_access_size;
  logic                      cpu_req_mem_access;
  logic [31:0]               cpu_data_in;
  logic                      cpu_wait_for_mem;
  logic                      cpu_access_err;
  logic                      mem_en;
  logic                      mem_we;
  logic [3:0]                mem_be;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]               mem_wdata;
  logic [31:0]               mem_rdata;

  modport slave (
    input  cpu_data_out, cpu_addr, cpu_access_type, cpu_access_size,
           cpu_req_mem_access, mem_rdata,
    output cpu_data_in, cpu_wait_for_mem, cpu_access_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output cpu_data_out, cpu_addr, cpu_access_type, cpu_access_size,
           cpu_req_mem_access, mem_rdata,
    input  cpu_data_in, cpu_wait_for_mem, cpu_access_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/frost32_mem_bridge.sv
// Frost32 CPU memory port to single-port synchronous RAM: lane steering, alignment check, read-latency sequencing.
// Optional access statistics counters enabled by defining FROST32_MEM_BRIDGE_STATS_EN.
`timescale 1ns/1ps
module frost32_mem_bridge #(
  parameter int MEM_ADDR_WIDTH   = 14,
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  frost32_mem_bridge_if.slave bus
`ifdef FROST32_MEM_BRIDGE_STATS_EN
  ,
  output logic [31:0] stat_reads,
  output logic [31:0] stat_writes,
  output logic [31:0] stat_errs,
  output logic [31:0] stat_stall_cycles
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

  localparam logic [1:0] WaitLoad = 2'(MEM_READ_LATENCY - 1);

  state_t                    state_r, state_next_s;
  logic [1:0]                addr_lo_r;
  logic [1:0]                size_r;
  logic                      type_r;
  logic [1:0]                cnt_r;
  logic [31:0]               data_in_r;
  logic                      access_err_r;
  logic                      mem_en_r, mem_we_r;
  logic [3:0]                mem_be_r;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_r;
  logic [31:0]               mem_wdata_r;
  logic                      accept_s, bad_s, wait_s;
  logic                      unused_addr_s;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return (lo != 2'd0);
      2'd1:    return lo[0];
      2'd2:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return 4'b1111;
      2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
      2'd2:    return 4'b0001 << lo;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    return d;
      2'd1:    return {2{d[15:0]}};
      2'd2:    return {4{d[7:0]}};
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Little-endian extraction: lane k holds the byte at addr[1:0]=k, result zero-extended.
  function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] lo,
                                          input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {lo, 3'b000};
    case (size)
      2'd0:    return w;
      2'd1:    return {16'h0000, sh[15:0]};
      2'd2:    return {24'h00_0000, sh[7:0]};
      default: return 32'h0000_0000;
    endcase
  endfunction

  assign accept_s      = (state_r == StIdle) && bus.cpu_req_mem_access;
  assign bad_s         = misaligned(bus.cpu_access_size, bus.cpu_addr[1:0]);
  assign wait_s        = accept_s || (state_r == StIssue) || (state_r == StWait);
  assign unused_addr_s = ^bus.cpu_addr[31:MEM_ADDR_WIDTH+2];

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      StIdle: begin
        if (bus.cpu_req_mem_access) state_next_s = bad_s ? StDone : StIssue;
        else                        state_next_s = StIdle;
      end
      StIssue: state_next_s = type_r ? StDone : StWait;
      StWait: begin
        if (cnt_r == 2'd0) state_next_s = StDone;
        else               state_next_s = StWait;
      end
      StDone:  state_next_s = StIdle;
      default: state_next_s = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= StIdle;
    else        state_r <= state_next_s;
  end

  // Request capture and read-latency down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_lo_r <= 2'd0;
      size_r    <= 2'd0;
      type_r    <= 1'b0;
      cnt_r     <= 2'd0;
    end else begin
      if (accept_s) begin
        addr_lo_r <= bus.cpu_addr[1:0];
        size_r    <= bus.cpu_access_size;
        type_r    <= bus.cpu_access_type;
      end
      if (state_r == StIssue)                      cnt_r <= WaitLoad;
      else if (state_r == StWait && cnt_r != 2'd0) cnt_r <= cnt_r - 2'd1;
      else                                         cnt_r <= cnt_r;
    end
  end

  // RAM strobes are registered so they are high for exactly the StIssue cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= 4'b0000;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      mem_en_r <= (state_next_s == StIssue);
      mem_we_r <= (state_next_s == StIssue) && bus.cpu_access_type;
      if (state_next_s == StIssue && bus.cpu_access_type)
        mem_be_r <= lane_mask(bus.cpu_access_size, bus.cpu_addr[1:0]);
      else
        mem_be_r <= 4'b0000;
      if (accept_s) begin
        mem_addr_r  <= bus.cpu_addr[MEM_ADDR_WIDTH+1:2];
        mem_wdata_r <= replicate(bus.cpu_access_size, bus.cpu_data_out);
      end
    end
  end

  // Read data return and error pulse, both updated only on entry to StDone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_in_r    <= 32'h0000_0000;
      access_err_r <= 1'b0;
    end else begin
      access_err_r <= (state_r == StIdle) && (state_next_s == StDone);
      if (state_r == StWait && state_next_s == StDone)
        data_in_r <= extract(size_r, addr_lo_r, bus.mem_rdata);
      else if (state_r != StWait && state_r != StDone && state_next_s == StDone)
        data_in_r <= 32'h0000_0000;
      else
        data_in_r <= data_in_r;
    end
  end

  assign bus.cpu_data_in      = data_in_r;
  assign bus.cpu_wait_for_mem = wait_s;
  assign bus.cpu_access_err   = access_err_r;
  assign bus.mem_en           = mem_en_r;
  assign bus.mem_we           = mem_we_r;
  assign bus.mem_be           = mem_be_r;
  assign bus.mem_addr         = mem_addr_r;
  assign bus.mem_wdata        = mem_wdata_r;

`ifdef FROST32_MEM_BRIDGE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && v != 32'hFFFF_FFFF) return v + 32'd1;
    else                          return v;
  endfunction

  // Saturating access statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reads        <= 32'h0000_0000;
      stat_writes       <= 32'h0000_0000;
      stat_errs         <= 32'h0000_0000;
      stat_stall_cycles <= 32'h0000_0000;
    end else begin
      stat_reads        <= sat_inc(stat_reads, state_r == StWait && state_next_s == StDone);
      stat_writes       <= sat_inc(stat_writes, state_r == StIssue && state_next_s == StDone);
      stat_errs         <= sat_inc(stat_errs, state_r == StIdle && state_next_s == StDone);
      stat_stall_cycles <= sat_inc(stat_stall_cycles, wait_s);
    end
  end
`endif

endmodule

// File: tb/tb_frost32_mem_bridge.sv
// Directed bench for frost32_mem_bridge: latency-1 and latency-3 instances, each with a behavioural RAM.
`timescale 1ns/1ps
module tb_frost32_mem_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] d_out = 32'h0;
  logic [31:0] addr = 32'h0;
  logic        typ = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        req = 1'b0;
  logic        sel = 1'b0;
  int          total = 0;
  int          bad = 0;

  frost32_mem_bridge_if #(.MEM_ADDR_WIDTH(14)) bus1();
  frost32_mem_bridge_if #(.MEM_ADDR_WIDTH(14)) bus3();

  assign bus1.cpu_data_out       = d_out;
  assign bus1.cpu_addr           = addr;
  assign bus1.cpu_access_type    = typ;
  assign bus1.cpu_access_size    = size;
  assign bus1.cpu_req_mem_access = req & ~sel;
  assign bus3.cpu_data_out       = d_out;
  assign bus3.cpu_addr           = addr;
  assign bus3.cpu_access_type    = typ;
  assign bus3.cpu_access_size    = size;
  assign bus3.cpu_req_mem_access = req & sel;

`ifdef FROST32_MEM_BRIDGE_STATS_EN
  logic [31:0] st_reads, st_writes, st_errs, st_stalls;
  logic [31:0] st3_reads, st3_writes, st3_errs, st3_stalls;
  frost32_mem_bridge #(.MEM_ADDR_WIDTH(14), .MEM_READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .stat_reads(st_reads), .stat_writes(st_writes), .stat_errs(st_errs),
    .stat_stall_cycles(st_stalls));
  frost32_mem_bridge #(.MEM_ADDR_WIDTH(14), .MEM_READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave),
    .stat_reads(st3_reads), .stat_writes(st3_writes), .stat_errs(st3_errs),
    .stat_stall_cycles(st3_stalls));
`else
  frost32_mem_bridge #(.MEM_ADDR_WIDTH(14), .MEM_READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  frost32_mem_bridge #(.MEM_ADDR_WIDTH(14), .MEM_READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave));
`endif

  // Latency-1 RAM: writable, read data valid one edge after the enable.
  logic [31:0] ram1 [0:16383];
  logic [31:0] pipe1;
  always @(posedge clk) begin
    if (bus1.mem_en && bus1.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus1.mem_be[b]) ram1[bus1.mem_addr][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
    pipe1 <= (bus1.mem_en && !bus1.mem_we) ? ram1[bus1.mem_addr] : 32'hBAD0_BAD0;
  end
  assign bus1.mem_rdata = pipe1;

  // Latency-3 RAM: preloaded, read-only; filler data outside the valid slot.
  logic [31:0] ram3 [0:16383];
  logic [31:0] pipe3 [0:2];
  always @(posedge clk) begin
    pipe3[0] <= (bus3.mem_en && !bus3.mem_we) ? ram3[bus3.mem_addr] : 32'hBAD3_BAD3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus3.mem_rdata = pipe3[2];

  logic        o_wait, o_en, o_we, o_err;
  logic [3:0]  o_be;
  logic [13:0] o_maddr;
  logic [31:0] o_wdata, o_data;
  assign o_wait  = sel ? bus3.cpu_wait_for_mem : bus1.cpu_wait_for_mem;
  assign o_en    = sel ? bus3.mem_en    : bus1.mem_en;
  assign o_we    = sel ? bus3.mem_we    : bus1.mem_we;
  assign o_err   = sel ? bus3.cpu_access_err : bus1.cpu_access_err;
  assign o_be    = sel ? bus3.mem_be    : bus1.mem_be;
  assign o_maddr = sel ? bus3.mem_addr  : bus1.mem_addr;
  assign o_wdata = sel ? bus3.mem_wdata : bus1.mem_wdata;
  assign o_data  = sel ? bus3.cpu_data_in : bus1.cpu_data_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access from request raise to the idle cycle after StDone.
  task automatic run_access(input logic s, input logic [31:0] a, input logic t,
                            input logic [1:0] sz, input logic [31:0] wd,
                            input int exp_done, input logic [31:0] exp_data,
                            input logic exp_err, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [13:0] exp_maddr);
    int done_c;
    int en_cnt;
    done_c = -1;
    en_cnt = 0;
    @(negedge clk);
    sel = s; addr = a; typ = t; size = sz; d_out = wd; req = 1'b1;
    #1;
    check("wait_c0", 32'(o_wait), 32'd1);
    check("en_c0", 32'(o_en), 32'd0);
    for (int c = 1; c <= 10 && done_c < 0; c++) begin
      @(negedge clk);
      if (o_en) begin
        en_cnt++;
        check("issue_cycle", c, 32'd1);
        check("mem_we", 32'(o_we), 32'(t));
        check("mem_addr", 32'(o_maddr), 32'(exp_maddr));
        if (t) begin
          check("mem_be", 32'(o_be), 32'(exp_be));
          check("mem_wdata", o_wdata, exp_wdata);
        end
      end
      if (!o_wait) done_c = c;
    end
    check("done_cycle", done_c, exp_done);
    check("data_in", o_data, exp_data);
    check("access_err", 32'(o_err), 32'(exp_err));
    check("en_pulses", en_cnt, exp_err ? 32'd0 : 32'd1);
    req = 1'b0;
    @(negedge clk);
    check("err_clear", 32'(o_err), 32'd0);
    check("wait_idle", 32'(o_wait), 32'd0);
    check("data_hold", o_data, exp_data);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram3[i] = 32'h0;
    ram3[4] = 32'hCAFE_F00D;
  end

  initial begin
    int en_cnt;
    repeat (2) @(negedge clk);
    check("rst_data_in", bus1.cpu_data_in, 32'h0);
    check("rst_en", 32'(bus1.mem_en), 32'd0);
    check("rst_wait", 32'(bus1.cpu_wait_for_mem), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_en", 32'(bus1.mem_en), 32'd0);
    check("post_rst_err", 32'(bus1.cpu_access_err), 32'd0);

    //           sel   addr           type  size  wdata          done data           err   be       exp_wdata      maddr
    run_access(1'b0, 32'h0000_0010, 1'b1, 2'd0, 32'hDEAD_BEEF, 2, 32'h0000_0000, 1'b0, 4'b1111, 32'hDEAD_BEEF, 14'd4);
    run_access(1'b0, 32'h0000_0012, 1'b0, 2'd1, 32'h0,         3, 32'h0000_DEAD, 1'b0, 4'b0000, 32'h0,         14'd4);
    run_access(1'b0, 32'h0000_0013, 1'b0, 2'd2, 32'h0,         3, 32'h0000_00DE, 1'b0, 4'b0000, 32'h0,         14'd4);
    run_access(1'b0, 32'h0000_0021, 1'b1, 2'd2, 32'h1234_565A, 2, 32'h0000_0000, 1'b0, 4'b0010, 32'h5A5A_5A5A, 14'd8);
    run_access(1'b0, 32'h0000_0021, 1'b0, 2'd2, 32'h0,         3, 32'h0000_005A, 1'b0, 4'b0000, 32'h0,         14'd8);
    run_access(1'b0, 32'h0000_0002, 1'b0, 2'd0, 32'h0,         1, 32'h0000_0000, 1'b1, 4'b0000, 32'h0,         14'd0);
    run_access(1'b0, 32'h0000_0000, 1'b1, 2'd3, 32'h1111_1111, 1, 32'h0000_0000, 1'b1, 4'b0000, 32'h0,         14'd0);
`ifdef FROST32_MEM_BRIDGE_STATS_EN
    check("stat_reads", st_reads, 32'd3);
    check("stat_writes", st_writes, 32'd2);
    check("stat_errs", st_errs, 32'd2);
    check("stat_stalls", st_stalls, 32'd15);
`endif
    run_access(1'b0, 32'h0000_001A, 1'b1, 2'd1, 32'h9999_ABCD, 2, 32'h0000_0000, 1'b0, 4'b1100, 32'hABCD_ABCD, 14'd6);
    run_access(1'b0, 32'h0000_001A, 1'b0, 2'd1, 32'h0,         3, 32'h0000_ABCD, 1'b0, 4'b0000, 32'h0,         14'd6);
    run_access(1'b0, 32'h0000_0011, 1'b1, 2'd1, 32'h0000_7777, 1, 32'h0000_0000, 1'b1, 4'b0000, 32'h0,         14'd0);
    run_access(1'b0, 32'h0001_0004, 1'b1, 2'd0, 32'h1122_3344, 2, 32'h0000_0000, 1'b0, 4'b1111, 32'h1122_3344, 14'd1);
    run_access(1'b0, 32'h0000_0004, 1'b0, 2'd0, 32'h0,         3, 32'h1122_3344, 1'b0, 4'b0000, 32'h0,         14'd1);
    run_access(1'b1, 32'h0000_0010, 1'b0, 2'd0, 32'h0,         5, 32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0,         14'd4);
    run_access(1'b0, 32'h0000_0010, 1'b0, 2'd0, 32'h0,         3, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0,         14'd4);

    // Reset in the middle of a latency-1 read, during StWait.
    @(negedge clk);
    sel = 1'b0; addr = 32'h0000_0012; typ = 1'b0; size = 2'd1; req = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_wait", 32'(bus1.cpu_wait_for_mem), 32'd1);
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    check("rst_mid_data", bus1.cpu_data_in, 32'h0);
    check("rst_mid_wait", 32'(bus1.cpu_wait_for_mem), 32'd0);
    check("rst_mid_en", 32'(bus1.mem_en), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus1.mem_en) en_cnt++;
    end
    check("no_strobe_after_rst", en_cnt, 32'd0);
    check("no_stale_data", bus1.cpu_data_in, 32'h0);
    run_access(1'b0, 32'h0000_0013, 1'b0, 2'd2, 32'h0,         3, 32'h0000_00DE, 1'b0, 4'b0000, 32'h0,         14'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
